// File: rtl/alu_pkg.sv
// Shared definitions for the 32-bit ALU and its result checker:
// control codes and the bit positions of the mismatch vector.
package alu_pkg;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_XOR  = 3'd2;
    localparam logic [2:0] ALU_SLT  = 3'd3;
    localparam logic [2:0] ALU_AND  = 3'd4;
    localparam logic [2:0] ALU_NAND = 3'd5;
    localparam logic [2:0] ALU_NOR  = 3'd6;
    localparam logic [2:0] ALU_OR   = 3'd7;

    // Positions inside the 4-bit {r,co,ofl,zero} mismatch vector
    localparam int MM_R    = 3;
    localparam int MM_CO   = 2;
    localparam int MM_OFL  = 1;
    localparam int MM_ZERO = 0;

endpackage

// File: rtl/alu_ref_model.sv
// Combinational golden model of the ALU: (ctrl, a, b) -> (r, co, ofl, zero).
// Kept free of state so benches can instantiate it directly.
module alu_ref_model
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       ctrl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] r,
    output logic             co,
    output logic             ofl,
    output logic             zero
);

    logic [WIDTH:0] sum_add;
    logic [WIDTH:0] sum_sub;
    logic           ofl_add;
    logic           ofl_sub;

    assign sum_add = {1'b0, a} + {1'b0, b};
    // Subtraction as a + ~b + 1 so the carry out reads as "no borrow"
    assign sum_sub = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};

    assign ofl_add = (a[WIDTH-1] == b[WIDTH-1]) && (sum_add[WIDTH-1] != a[WIDTH-1]);
    assign ofl_sub = (a[WIDTH-1] != b[WIDTH-1]) && (sum_sub[WIDTH-1] != a[WIDTH-1]);

    always_comb begin
        r   = '0;
        co  = 1'b0;
        ofl = 1'b0;
        case (ctrl)
            ALU_ADD: begin
                r   = sum_add[WIDTH-1:0];
                co  = sum_add[WIDTH];
                ofl = ofl_add;
            end
            ALU_SUB: begin
                r   = sum_sub[WIDTH-1:0];
                co  = sum_sub[WIDTH];
                ofl = ofl_sub;
            end
            ALU_XOR:  r = a ^ b;
            // Signed less-than from the subtractor: sign corrected by overflow
            ALU_SLT:  r = {{(WIDTH-1){1'b0}}, sum_sub[WIDTH-1] ^ ofl_sub};
            ALU_AND:  r = a & b;
            ALU_NAND: r = ~(a & b);
            ALU_NOR:  r = ~(a | b);
            ALU_OR:   r = a | b;
            default:  r = '0;
        endcase
    end

    assign zero = (r == '0);

endmodule

// File: rtl/alu_result_checker.sv
// Two-stage valid/ready checker: S1 captures the observed tuple with the reference
// expectation, S2 holds the verdict; counters and first-failure capture update on consumption.
module alu_result_checker
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_ctrl,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_r,
    input  logic             in_co,
    input  logic             in_ofl,
    input  logic             in_zero,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_pass,
    output logic [3:0]       res_mismatch,
    output logic [CNT_W-1:0] pass_count,
    output logic [CNT_W-1:0] fail_count,
    output logic             err_sticky,
    output logic [2:0]       err_ctrl,
    output logic [WIDTH-1:0] err_a,
    output logic [WIDTH-1:0] err_b,
    output logic [WIDTH-1:0] err_r
);

    logic [WIDTH-1:0] exp_r;
    logic             exp_co;
    logic             exp_ofl;
    logic             exp_zero;

    logic             s1_valid;
    logic [2:0]       s1_ctrl;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [WIDTH-1:0] s1_r;
    logic             s1_co;
    logic             s1_ofl;
    logic             s1_zero;
    logic [WIDTH-1:0] s1_exp_r;
    logic             s1_exp_co;
    logic             s1_exp_ofl;
    logic             s1_exp_zero;
    logic [3:0]       s1_mismatch;

    logic [2:0]       s2_ctrl;
    logic [WIDTH-1:0] s2_a;
    logic [WIDTH-1:0] s2_b;
    logic [WIDTH-1:0] s2_r;

    logic             s2_load;
    logic             consume;

    alu_ref_model #(.WIDTH(WIDTH)) u_ref (
        .ctrl (in_ctrl),
        .a    (in_a),
        .b    (in_b),
        .r    (exp_r),
        .co   (exp_co),
        .ofl  (exp_ofl),
        .zero (exp_zero)
    );

    // S2 can take a new entry when empty or when its verdict leaves this cycle
    assign s2_load  = !res_valid || res_ready;
    assign in_ready = !reset && (!s1_valid || s2_load);
    assign consume  = res_valid && res_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid    <= 1'b0;
            s1_ctrl     <= '0;
            s1_a        <= '0;
            s1_b        <= '0;
            s1_r        <= '0;
            s1_co       <= 1'b0;
            s1_ofl      <= 1'b0;
            s1_zero     <= 1'b0;
            s1_exp_r    <= '0;
            s1_exp_co   <= 1'b0;
            s1_exp_ofl  <= 1'b0;
            s1_exp_zero <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_ctrl     <= in_ctrl;
                s1_a        <= in_a;
                s1_b        <= in_b;
                s1_r        <= in_r;
                s1_co       <= in_co;
                s1_ofl      <= in_ofl;
                s1_zero     <= in_zero;
                s1_exp_r    <= exp_r;
                s1_exp_co   <= exp_co;
                s1_exp_ofl  <= exp_ofl;
                s1_exp_zero <= exp_zero;
            end
        end
    end

    always_comb begin
        s1_mismatch          = '0;
        s1_mismatch[MM_R]    = (s1_r    != s1_exp_r);
        s1_mismatch[MM_CO]   = (s1_co   != s1_exp_co);
        s1_mismatch[MM_OFL]  = (s1_ofl  != s1_exp_ofl);
        s1_mismatch[MM_ZERO] = (s1_zero != s1_exp_zero);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_valid    <= 1'b0;
            res_pass     <= 1'b0;
            res_mismatch <= '0;
            s2_ctrl      <= '0;
            s2_a         <= '0;
            s2_b         <= '0;
            s2_r         <= '0;
        end else if (s2_load) begin
            res_valid <= s1_valid;
            if (s1_valid) begin
                res_pass     <= (s1_mismatch == 4'b0000);
                res_mismatch <= s1_mismatch;
                s2_ctrl      <= s1_ctrl;
                s2_a         <= s1_a;
                s2_b         <= s1_b;
                s2_r         <= s1_r;
            end
        end
    end

    // clear takes priority over a verdict consumed in the same cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pass_count <= '0;
            fail_count <= '0;
            err_sticky <= 1'b0;
            err_ctrl   <= '0;
            err_a      <= '0;
            err_b      <= '0;
            err_r      <= '0;
        end else if (clear) begin
            pass_count <= '0;
            fail_count <= '0;
            err_sticky <= 1'b0;
            err_ctrl   <= '0;
            err_a      <= '0;
            err_b      <= '0;
            err_r      <= '0;
        end else if (consume) begin
            if (res_pass) begin
                if (pass_count != {CNT_W{1'b1}}) begin
                    pass_count <= pass_count + CNT_W'(1);
                end
            end else begin
                if (fail_count != {CNT_W{1'b1}}) begin
                    fail_count <= fail_count + CNT_W'(1);
                end
                if (!err_sticky) begin
                    err_sticky <= 1'b1;
                    err_ctrl   <= s2_ctrl;
                    err_a      <= s2_a;
                    err_b      <= s2_b;
                    err_r      <= s2_r;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_result_checker.sv
// Directed bench for alu_result_checker: stimulus pushes hand-computed verdicts into a
// scoreboard queue, a monitor pops and compares each consumed verdict.
module tb_alu_result_checker;
    import alu_pkg::*;

    localparam int WIDTH = 32;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             clear;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_ctrl;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [WIDTH-1:0] in_r;
    logic             in_co;
    logic             in_ofl;
    logic             in_zero;
    logic             res_valid;
    logic             res_ready;
    logic             res_pass;
    logic [3:0]       res_mismatch;
    logic [CNT_W-1:0] pass_count;
    logic [CNT_W-1:0] fail_count;
    logic             err_sticky;
    logic [2:0]       err_ctrl;
    logic [WIDTH-1:0] err_a;
    logic [WIDTH-1:0] err_b;
    logic [WIDTH-1:0] err_r;

    typedef struct {
        logic       pass;
        logic [3:0] mm;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   n_acc    = 0;

    alu_result_checker #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .clear        (clear),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_ctrl      (in_ctrl),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_r         (in_r),
        .in_co        (in_co),
        .in_ofl       (in_ofl),
        .in_zero      (in_zero),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_pass     (res_pass),
        .res_mismatch (res_mismatch),
        .pass_count   (pass_count),
        .fail_count   (fail_count),
        .err_sticky   (err_sticky),
        .err_ctrl     (err_ctrl),
        .err_a        (err_a),
        .err_b        (err_b),
        .err_r        (err_r)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 right after the accepting edge
    task automatic send(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] r, input logic co, input logic ofl, input logic z,
                        input logic [3:0] mm);
        int t;
        t        = 0;
        in_valid = 1'b1;
        in_ctrl  = c;
        in_a     = a;
        in_b     = b;
        in_r     = r;
        in_co    = co;
        in_ofl   = ofl;
        in_zero  = z;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            t++;
            if (t > 60) begin
                chk("accept_timeout", 32'(in_ready), 32'd1);
                in_valid = 1'b0;
                return;
            end
        end
        sb.push_back('{(mm == 4'b0000), mm});
        n_acc++;
        $display("send ctrl=%0d a=%h b=%h r=%h co=%b ofl=%b zero=%b exp_mm=%b", c, a, b, r, co, ofl, z, mm);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((sb.size() != 0 || res_valid) && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) chk("drain_timeout", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_res_valid();
        int t;
        t = 0;
        while (!res_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("res_valid_seen", 32'(res_valid), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    task automatic chk_counts(input string tag, input int p, input int f);
        chk({tag, "_pass_count"}, 32'(pass_count), 32'(p));
        chk({tag, "_fail_count"}, 32'(fail_count), 32'(f));
    endtask

    // Monitor: one comparison pair per consumed verdict
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && res_valid && res_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_verdict actual=pass%b/mm%b required=none", res_pass, res_mismatch);
                end else begin
                    e = sb.pop_front();
                    $display("verdict pass=%b mm=%b exp_pass=%b exp_mm=%b", res_pass, res_mismatch, e.pass, e.mm);
                    chk("res_pass", 32'(res_pass), 32'(e.pass));
                    chk("res_mismatch", 32'(res_mismatch), 32'(e.mm));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; clear = 1'b0; in_valid = 1'b0; res_ready = 1'b1;
        in_ctrl = '0; in_a = '0; in_b = '0; in_r = '0;
        in_co = 1'b0; in_ofl = 1'b0; in_zero = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk_counts("rst", 0, 0);
        chk("rst_err_sticky", 32'(err_sticky), 32'd0);
        reset = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // 1: ADD overflow, pass, 2-cycle latency
        send(ALU_ADD, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'hFFFFFFFE, 1'b0, 1'b1, 1'b0, 4'b0000);
        @(negedge clk);
        chk("lat_s1_only", 32'(res_valid), 32'd0);
        @(negedge clk);
        chk("lat_res_valid", 32'(res_valid), 32'd1);
        @(posedge clk);
        #1;
        wait_drain();
        chk_counts("t1", 1, 0);

        // 2: SUB equal operands, pass then zero-flag failure
        send(ALU_SUB, 32'h12345678, 32'h12345678, 32'h0, 1'b1, 1'b0, 1'b1, 4'b0000);
        send(ALU_SUB, 32'h12345678, 32'h12345678, 32'h0, 1'b1, 1'b0, 1'b0, 4'b0001);
        wait_drain();
        chk_counts("t2", 2, 1);
        chk("t2_err_sticky", 32'(err_sticky), 32'd1);
        chk("t2_err_a", err_a, 32'h12345678);
        chk("t2_err_ctrl", 32'(err_ctrl), 32'(ALU_SUB));

        // 3: SLT signed compare, NOR with spurious carry
        send(ALU_SLT, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h1, 1'b0, 1'b0, 1'b0, 4'b0000);
        send(ALU_NOR, 32'hFFFFFFFF, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 4'b0100);
        wait_drain();
        chk_counts("t3", 3, 2);
        chk("t3_err_a_held", err_a, 32'h12345678);
        pulse_clear();
        chk_counts("clr", 0, 0);
        chk("clr_err_sticky", 32'(err_sticky), 32'd0);
        chk("clr_err_a", err_a, 32'h0);

        // 4: burst of 8 with the consumer stalled
        res_ready = 1'b0;
        n_acc     = 0;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    send(ALU_XOR, 32'(i), 32'h0, (i % 2 != 0) ? 32'(i + 100) : 32'(i),
                         1'b0, 1'b0, (i == 0), (i % 2 != 0) ? 4'b1000 : 4'b0000);
                end
            end
            begin
                int t;
                t = 0;
                while (n_acc < 2 && t < 50) begin
                    @(negedge clk);
                    t++;
                end
                repeat (3) @(negedge clk);
                chk("burst_in_ready_low", 32'(in_ready), 32'd0);
                chk("burst_accepts", 32'(n_acc), 32'd2);
                chk("burst_res_valid", 32'(res_valid), 32'd1);
                @(posedge clk);
                #1;
                res_ready = 1'b1;
            end
        join
        wait_drain();
        chk_counts("t4", 4, 4);
        chk("t4_err_a", err_a, 32'h1);
        chk("t4_err_r", err_r, 32'h65);
        chk("t4_err_ctrl", 32'(err_ctrl), 32'(ALU_XOR));

        // 5: consecutive failures keep the first; clear coincident with consumption
        pulse_clear();
        send(ALU_AND, 32'hF0, 32'hFF, 32'h0, 1'b0, 1'b0, 1'b1, 4'b1001);
        send(ALU_OR, 32'h1, 32'h2, 32'h3, 1'b0, 1'b1, 1'b0, 4'b0010);
        wait_drain();
        chk_counts("t5", 0, 2);
        chk("t5_err_a_first", err_a, 32'hF0);
        chk("t5_err_b_first", err_b, 32'hFF);
        chk("t5_err_ctrl_first", 32'(err_ctrl), 32'(ALU_AND));

        res_ready = 1'b0;
        send(ALU_OR, 32'h1, 32'h2, 32'h3, 1'b0, 1'b0, 1'b0, 4'b0000);
        wait_res_valid();
        res_ready = 1'b1;
        clear     = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        chk_counts("t5_clr_pass", 0, 0);
        chk("t5_clr_sticky", 32'(err_sticky), 32'd0);

        res_ready = 1'b0;
        send(ALU_OR, 32'h1, 32'h2, 32'h7, 1'b0, 1'b0, 1'b0, 4'b1000);
        wait_res_valid();
        res_ready = 1'b1;
        clear     = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        chk_counts("t5_clr_fail", 0, 0);
        chk("t5_clr_fail_sticky", 32'(err_sticky), 32'd0);
        chk("t5_clr_fail_err_r", err_r, 32'h0);

        // 6: saturation at 15 with a 4-bit counter
        for (int i = 0; i < 15; i++) begin
            send(ALU_OR, 32'h1, 32'h2, 32'h3, 1'b0, 1'b0, 1'b0, 4'b0000);
        end
        wait_drain();
        chk_counts("t6_full", 15, 0);
        send(ALU_OR, 32'h1, 32'h2, 32'h3, 1'b0, 1'b0, 1'b0, 4'b0000);
        wait_drain();
        chk_counts("t6_sat", 15, 0);

        // Reset with both stages occupied
        res_ready = 1'b0;
        send(ALU_ADD, 32'h1, 32'h1, 32'h2, 1'b0, 1'b0, 1'b0, 4'b0000);
        send(ALU_ADD, 32'h2, 32'h2, 32'h4, 1'b0, 1'b0, 1'b0, 4'b0000);
        @(negedge clk);
        chk("full_res_valid", 32'(res_valid), 32'd1);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("mid_rst_res_valid", 32'(res_valid), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        chk_counts("mid_rst", 0, 0);
        sb.delete();
        @(posedge clk);
        #1;
        reset     = 1'b0;
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("after_rst_res_valid", 32'(res_valid), 32'd0);
        chk("after_rst_in_ready", 32'(in_ready), 32'd1);
        send(ALU_SUB, 32'h5, 32'h3, 32'h2, 1'b1, 1'b0, 1'b0, 4'b0000);
        wait_drain();
        chk_counts("after_rst", 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
